serial_tc_decoder: RTL and testbench

Bit-serial two's-complement-to-sign-magnitude decoder. It accepts a WIDTH-bit two's-complement word one bit per accepted cycle, LSB first, and presents the word as a registered parallel sign bit plus unsigned magnitude. The negated value is computed on the fly with a seen-first-one Mealy machine, in parallel with the raw shift. The block sits on the receive side of the serial arithmetic path, opposite the serial two's complementer.

---
 rtl/serial_tc_pkg.sv | 11 +
 rtl/serial_negator.sv | 34 +++
 rtl/serial_tc_decoder.sv | 132 +++++++++++++
 tb/tb_serial_tc_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tc_pkg.sv
// Shared types and defaults for the bit-serial two's-complement decoder.
package serial_tc_pkg;

   localparam int unsigned WIDTH_DEF = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/serial_negator.sv
// Seen-first-one serial negator: passes bits up to and including the first 1,
// inverts every bit after it. Mealy output, one flop of state.
module serial_negator (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic inp,
   output logic neg_bit
);

   logic seen_q;
   logic seen_d;
   logic seen_eff;

   always_comb begin
      seen_d   = seen_q;
      // clr marks bit 0, so the stale flag from the previous word is ignored
      seen_eff = clr ? 1'b0 : seen_q;
      neg_bit  = seen_eff ? ~inp : inp;
      if (en) begin
         seen_d = seen_eff | inp;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seen_q <= 1'b0;
      end else begin
         seen_q <= seen_d;
      end
   end

endmodule

// File: rtl/serial_tc_decoder.sv
// LSB-first serial two's-complement word to registered sign + magnitude.
// Optional SERIAL_TC_FRAME_ERR_EN adds a pulse on restart while busy.
module serial_tc_decoder
   import serial_tc_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inp,
   input  logic             in_valid,
   input  logic             start,
   output logic             busy,
   output logic             out_valid,
   output logic             sign,
   output logic [WIDTH-1:0] mag,
   output logic             frame_err
);

   localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] raw_q, raw_d;
   logic [WIDTH-1:0] neg_q, neg_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic             sign_q, sign_d;
   logic             busy_q, busy_d;
   logic             out_valid_q, out_valid_d;

   logic             bit0_c;
   logic             accept_c;
   logic             neg_bit_c;
   logic [WIDTH-1:0] raw_nxt_c;
   logic [WIDTH-1:0] neg_nxt_c;

   assign bit0_c    = in_valid & start;
   assign accept_c  = in_valid & (start | (state_q == SHIFT));
   assign raw_nxt_c = {inp, raw_q[WIDTH-1:1]};
   assign neg_nxt_c = {neg_bit_c, neg_q[WIDTH-1:1]};

   serial_negator u_negator (
      .clk    (clk),
      .reset  (reset),
      .clr    (bit0_c),
      .en     (accept_c),
      .inp    (inp),
      .neg_bit(neg_bit_c)
   );

   // Next-state and output-register logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      raw_d       = raw_q;
      neg_d       = neg_q;
      sign_d      = sign_q;
      mag_d       = mag_q;
      out_valid_d = 1'b0;

      if (accept_c) begin
         raw_d = raw_nxt_c;
         neg_d = neg_nxt_c;
      end

      if (bit0_c) begin
         state_d = SHIFT;
         cnt_d   = CNT_W'(1);
      end else if ((state_q == SHIFT) && in_valid) begin
         if (cnt_q == CNT_LAST) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            sign_d      = inp;
            mag_d       = inp ? neg_nxt_c : raw_nxt_c;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      busy_d = (state_d == SHIFT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         raw_q       <= '0;
         neg_q       <= '0;
         sign_q      <= 1'b0;
         mag_q       <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         raw_q       <= raw_d;
         neg_q       <= neg_d;
         sign_q      <= sign_d;
         mag_q       <= mag_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign sign      = sign_q;
   assign mag       = mag_q;

`ifdef SERIAL_TC_FRAME_ERR_EN
   logic frame_err_q, frame_err_d;

   always_comb begin
      frame_err_d = (state_q == SHIFT) & bit0_c;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
      end
   end

   assign frame_err = frame_err_q;
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_tc_decoder.sv
// Randomized self-checking bench for serial_tc_decoder against an integer model.
module tb_serial_tc_decoder;

   localparam int W = 8;

   typedef struct {
      logic         s;
      logic [W-1:0] m;
   } res_t;

   logic         clk;
   logic         reset;
   logic         inp;
   logic         in_valid;
   logic         start;
   logic         busy;
   logic         out_valid;
   logic         sign;
   logic [W-1:0] mag;
   logic         frame_err;

   int   checks;
   int   errors;
   int   fe_cnt;
   res_t q[$];

   serial_tc_decoder #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .inp      (inp),
      .in_valid (in_valid),
      .start    (start),
      .busy     (busy),
      .out_valid(out_valid),
      .sign     (sign),
      .mag      (mag),
      .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Collect every completed result and every frame_err pulse
   always @(negedge clk) begin
      if (out_valid === 1'b1) q.push_back('{sign, mag});
      if (frame_err === 1'b1) fe_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference: interpret the word as a signed integer, take sign and |value|
   function automatic void model(input logic [W-1:0] w, output logic s, output logic [W-1:0] m);
      int v;
      v = w[W-1] ? int'(w) - (1 << W) : int'(w);
      s = (v < 0);
      m = W'(v < 0 ? -v : v);
   endfunction

   task automatic drive(input logic b, input logic v, input logic s);
      @(negedge clk);
      inp      = b;
      in_valid = v;
      start    = s;
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'($urandom), 1'b0, 1'($urandom));
   endtask

   task automatic send_word(input logic [W-1:0] w, input int gap_pct);
      for (int i = 0; i < W; i++) begin
         drive(w[i], 1'b1, i == 0);
         if (i != W - 1) begin
            while (int'($urandom_range(99)) < gap_pct) drive(1'($urandom), 1'b0, 1'($urandom));
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      inp = 1'b1; in_valid = 1'b1; start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (sign !== 1'b0) begin errors++; $display("FAIL reset_sign got %b exp 0", sign); end
      checks++; if (mag !== '0) begin errors++; $display("FAIL reset_mag got %0d exp 0", mag); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
      @(negedge clk);
      in_valid = 1'b0; start = 1'b0;
      reset = 1'b1;
      idle(2);
      q.delete();
   endtask

   task automatic test_directed;
      logic [W-1:0] vec[5] = '{8'h05, 8'hFA, 8'h00, 8'h80, 8'h7F};
      logic es;
      logic [W-1:0] em;
      res_t r;
      foreach (vec[k]) begin
         q.delete();
         send_word(vec[k], 0);
         idle(2);
         model(vec[k], es, em);
         checks++;
         if (q.size() != 1) begin
            errors++; $display("FAIL directed_%0h_count got %0d exp 1", vec[k], q.size());
         end
         if (q.size() > 0) begin
            r = q.pop_front();
            checks++; if (r.s !== es) begin errors++; $display("FAIL directed_%0h_sign got %b exp %b", vec[k], r.s, es); end
            checks++; if (r.m !== em) begin errors++; $display("FAIL directed_%0h_mag got %0d exp %0d", vec[k], r.m, em); end
         end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL directed_%0h_busy_after got %b exp 0", vec[k], busy); end
      end
   endtask

   task automatic test_gaps;
      logic [W-1:0] w = 8'hFD;
      res_t r;
      q.delete();
      for (int i = 0; i < W; i++) begin
         drive(w[i], 1'b1, i == 0);
         if (i == 2 || i == 5) begin
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b1);
            #1;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gaps_busy_hold got %b exp 1", busy); end
         end
      end
      idle(3);
      checks++;
      if (q.size() != 1) begin errors++; $display("FAIL gaps_count got %0d exp 1", q.size()); end
      if (q.size() > 0) begin
         r = q.pop_front();
         checks++; if (r.s !== 1'b1) begin errors++; $display("FAIL gaps_sign got %b exp 1", r.s); end
         checks++; if (r.m !== W'(3)) begin errors++; $display("FAIL gaps_mag got %0d exp 3", r.m); end
      end
   endtask

   task automatic test_restart;
      res_t r;
      int exp_fe;
`ifdef SERIAL_TC_FRAME_ERR_EN
      exp_fe = 1;
`else
      exp_fe = 0;
`endif
      q.delete();
      fe_cnt = 0;
      for (int i = 0; i < 4; i++) drive(1'($urandom), 1'b1, i == 0);
      send_word(8'hFF, 0);
      idle(2);
      checks++;
      if (q.size() != 1) begin errors++; $display("FAIL restart_count got %0d exp 1", q.size()); end
      if (q.size() > 0) begin
         r = q.pop_front();
         checks++; if (r.s !== 1'b1) begin errors++; $display("FAIL restart_sign got %b exp 1", r.s); end
         checks++; if (r.m !== W'(1)) begin errors++; $display("FAIL restart_mag got %0d exp 1", r.m); end
      end
      checks++; if (fe_cnt != exp_fe) begin errors++; $display("FAIL restart_frame_err got %0d exp %0d", fe_cnt, exp_fe); end
   endtask

   task automatic test_reset_mid;
      logic [W-1:0] w = 8'hB3;
      res_t r;
      q.delete();
      for (int i = 0; i < 6; i++) drive(w[i], 1'b1, i == 0);
      @(negedge clk);
      inp = w[6]; in_valid = 1'b1; start = 1'b0;
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL resetmid_busy got %b exp 0", busy); end
      checks++; if (mag !== '0) begin errors++; $display("FAIL resetmid_mag got %0d exp 0", mag); end
      @(negedge clk);
      inp = w[7];
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b1;
      idle(2);
      checks++; if (q.size() != 0) begin errors++; $display("FAIL resetmid_stale got %0d exp 0", q.size()); end
      q.delete();
      send_word(8'h09, 0);
      idle(2);
      checks++;
      if (q.size() != 1) begin errors++; $display("FAIL resetmid_count got %0d exp 1", q.size()); end
      if (q.size() > 0) begin
         r = q.pop_front();
         checks++; if (r.s !== 1'b0) begin errors++; $display("FAIL resetmid_sign got %b exp 0", r.s); end
         checks++; if (r.m !== W'(9)) begin errors++; $display("FAIL resetmid_mag9 got %0d exp 9", r.m); end
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] w[3];
      logic es;
      logic [W-1:0] em;
      res_t r;
      q.delete();
      fe_cnt = 0;
      foreach (w[k]) w[k] = W'($urandom);
      foreach (w[k]) send_word(w[k], 0);
      idle(2);
      checks++;
      if (q.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", q.size()); end
      foreach (w[k]) begin
         if (q.size() > 0) begin
            r = q.pop_front();
            model(w[k], es, em);
            checks++;
            if (r.s !== es || r.m !== em) begin
               errors++; $display("FAIL b2b_%0h got s=%b m=%0d exp s=%b m=%0d", w[k], r.s, r.m, es, em);
            end
         end
      end
      checks++; if (fe_cnt != 0) begin errors++; $display("FAIL b2b_frame_err got %0d exp 0", fe_cnt); end
   endtask

   task automatic test_random;
      logic [W-1:0] w;
      logic es;
      logic [W-1:0] em;
      res_t r;
      for (int n = 0; n < 40; n++) begin
         q.delete();
         w = W'($urandom);
         if (n == 0) w = 8'h80;
         if (n == 1) w = 8'hFF;
         send_word(w, 30);
         idle(int'($urandom_range(2, 3)));
         model(w, es, em);
         checks++;
         if (q.size() != 1) begin
            errors++; $display("FAIL rand_%0h_count got %0d exp 1", w, q.size());
         end else begin
            r = q.pop_front();
            if (r.s !== es || r.m !== em) begin
               errors++; $display("FAIL rand_%0h got s=%b m=%0d exp s=%b m=%0d", w, r.s, r.m, es, em);
            end
         end
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      fe_cnt   = 0;
      inp      = 1'b0;
      in_valid = 1'b0;
      start    = 1'b0;
      reset    = 1'b1;
      test_reset;
      test_directed;
      test_gaps;
      test_restart;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
